// File: rtl/alu_pkg.sv
// Shared types for the divider issue controller: sequencer states, result-select codes, MIN detection.
package alu_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} div_seq_e;

    typedef enum logic [1:0] {RES_DIV, RES_DZ, RES_OVF, RES_TMO} res_sel_e;

    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned WDOG_W    = 8;

    // True when the low 'width' bits of x hold the most negative two's-complement value.
    function automatic logic is_min(input logic [MAX_WIDTH-1:0] x, input int unsigned width);
        logic [MAX_WIDTH-1:0] min_val;
        min_val = MAX_WIDTH'(1) << (width - 1);
        return x == min_val;
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Combinational result former: remainder sign restore for real divides, fixed codes for screened cases.
module div_sign_fix
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  res_sel_e           sel,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   q_raw,
    input  logic [WIDTH-1:0]   r_mag,
    output logic [WIDTH-1:0]   q_c,
    output logic [WIDTH-1:0]   r_c,
    output logic               dz_c,
    output logic               ovf_c
);

    always_comb begin
        q_c   = '0;
        r_c   = '0;
        dz_c  = 1'b0;
        ovf_c = 1'b0;
        unique case (sel)
            RES_DIV: begin
                q_c = q_raw;
                // Remainder takes the dividend's sign; negating zero yields zero.
                r_c = a[WIDTH-1] ? (~r_mag + WIDTH'(1)) : r_mag;
            end
            RES_DZ: begin
                q_c  = '1;
                r_c  = a;
                dz_c = 1'b1;
            end
            RES_OVF: begin
                q_c   = {1'b1, {(WIDTH-1){1'b0}}};
                ovf_c = 1'b1;
            end
            RES_TMO: begin
                dz_c  = 1'b1;
                ovf_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue sequencer for the signed divider: screens /0 and MIN/-1, launches the divider, holds the result.
// Optional watchdog on the divider wait enabled by defining DIV_TIMEOUT_EN.
module div_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TMO_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               req_vld,
    output logic               req_rdy,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic               div_bgn,
    output logic [WIDTH-1:0]   div_ibusA,
    output logic [WIDTH-1:0]   div_ibusB,
    input  logic [WIDTH-1:0]   div_obusA,
    input  logic [WIDTH-1:0]   div_obusB,
    input  logic               div_fin,
    output logic               rsp_vld,
    input  logic               rsp_rdy,
    output logic [WIDTH-1:0]   rsp_q,
    output logic [WIDTH-1:0]   rsp_r,
    output logic               rsp_dz,
    output logic               rsp_ovf
);

    div_seq_e          state, state_d;
    logic [WIDTH-1:0]  op_a_d, op_b_d, q_d, r_d;
    logic              dz_d, ovf_d, bgn_d, load_rsp;
    res_sel_e          fix_sel;
    logic [WIDTH-1:0]  fix_a, fix_q, fix_r;
    logic              fix_dz, fix_ovf;
`ifdef DIV_TIMEOUT_EN
    logic [WDOG_W-1:0] wdog, wdog_d;
`endif

    div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .sel   (fix_sel),
        .a     (fix_a),
        .q_raw (div_obusA),
        .r_mag (div_obusB),
        .q_c   (fix_q),
        .r_c   (fix_r),
        .dz_c  (fix_dz),
        .ovf_c (fix_ovf)
    );

    // Next-state and next-register values; the operand registers double as the divider input bus.
    always_comb begin
        state_d  = state;
        op_a_d   = div_ibusA;
        op_b_d   = div_ibusB;
        q_d      = rsp_q;
        r_d      = rsp_r;
        dz_d     = rsp_dz;
        ovf_d    = rsp_ovf;
        bgn_d    = 1'b0;
        load_rsp = 1'b0;
        fix_sel  = RES_DIV;
        fix_a    = div_ibusA;
`ifdef DIV_TIMEOUT_EN
        wdog_d   = wdog;
`endif
        unique case (state)
            IDLE: begin
                // Short-circuit results are formed straight from the request so they land one cycle after accept.
                fix_a = req_a;
                if (req_vld && req_rdy) begin
                    op_a_d = req_a;
                    op_b_d = req_b;
                    if (req_b == '0) begin
                        fix_sel  = RES_DZ;
                        load_rsp = 1'b1;
                        state_d  = DONE;
                    end else if (is_min(MAX_WIDTH'(req_a), WIDTH) && (req_b == '1)) begin
                        fix_sel  = RES_OVF;
                        load_rsp = 1'b1;
                        state_d  = DONE;
                    end else begin
                        bgn_d   = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef DIV_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            WAIT: begin
                if (div_fin) begin
                    fix_sel  = RES_DIV;
                    load_rsp = 1'b1;
                    state_d  = DONE;
                end
`ifdef DIV_TIMEOUT_EN
                else if (wdog == WDOG_W'(TMO_CYC - 1)) begin
                    fix_sel  = RES_TMO;
                    load_rsp = 1'b1;
                    state_d  = DONE;
                end else begin
                    wdog_d = wdog + WDOG_W'(1);
                end
`endif
            end
            DONE: begin
                if (rsp_rdy) begin
                    state_d = IDLE;
                end
            end
        endcase
        if (load_rsp) begin
            q_d   = fix_q;
            r_d   = fix_r;
            dz_d  = fix_dz;
            ovf_d = fix_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            req_rdy   <= 1'b1;
            div_bgn   <= 1'b0;
            div_ibusA <= '0;
            div_ibusB <= '0;
            rsp_vld   <= 1'b0;
            rsp_q     <= '0;
            rsp_r     <= '0;
            rsp_dz    <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else begin
            state     <= state_d;
            req_rdy   <= (state_d == IDLE);
            div_bgn   <= bgn_d;
            div_ibusA <= op_a_d;
            div_ibusB <= op_b_d;
            rsp_vld   <= (state_d == DONE);
            rsp_q     <= q_d;
            rsp_r     <= r_d;
            rsp_dz    <= dz_d;
            rsp_ovf   <= ovf_d;
        end
    end

`ifdef DIV_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wdog <= '0;
        end else begin
            wdog <= wdog_d;
        end
    end
`endif

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider that answers a fixed number of cycles after bgn.
module tb_div_issue_ctrl;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         req_vld = 1'b0;
    logic         req_rdy;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         div_bgn;
    logic [W-1:0] div_ibusA, div_ibusB;
    logic [W-1:0] div_obusA, div_obusB;
    logic         div_fin;
    logic         rsp_vld;
    logic         rsp_rdy = 1'b0;
    logic [W-1:0] rsp_q, rsp_r;
    logic         rsp_dz, rsp_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    div_issue_ctrl #(.WIDTH(W), .TMO_CYC(255)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_a     (req_a),
        .req_b     (req_b),
        .div_bgn   (div_bgn),
        .div_ibusA (div_ibusA),
        .div_ibusB (div_ibusB),
        .div_obusA (div_obusA),
        .div_obusB (div_obusB),
        .div_fin   (div_fin),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_dz    (rsp_dz),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    // Divider model: quotient and remainder magnitude appear with a one-cycle fin, garbage otherwise.
    int           dly = 3;
    logic         fin_en = 1'b1;
    int           cnt;
    int           bgn_total;
    logic [W-1:0] mq, mr, cap_a, cap_b;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt       <= 0;
            bgn_total <= 0;
            div_fin   <= 1'b0;
            div_obusA <= 32'hDEADBEEF;
            div_obusB <= 32'hCAFEF00D;
        end else begin
            div_fin   <= 1'b0;
            div_obusA <= 32'hDEADBEEF;
            div_obusB <= 32'hCAFEF00D;
            if (div_bgn) begin
                bgn_total <= bgn_total + 1;
                cap_a     <= div_ibusA;
                cap_b     <= div_ibusB;
            end
            if (div_bgn && fin_en) begin
                cnt <= dly;
                mq  <= W'($signed(div_ibusA) / $signed(div_ibusB));
                mr  <= ($signed(div_ibusA) % $signed(div_ibusB)) < 0
                       ? W'(-($signed(div_ibusA) % $signed(div_ibusB)))
                       : W'($signed(div_ibusA) % $signed(div_ibusB));
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    div_fin   <= 1'b1;
                    div_obusA <= mq;
                    div_obusB <= mr;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard = 0;
        while (!req_rdy && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (!req_rdy) begin
            n_bad++;
            $display("FAIL send_rdy_timeout got req_rdy=%b exp 1", req_rdy);
        end
        req_a   = a;
        req_b   = b;
        req_vld = 1'b1;
        @(posedge clk); #1;
        req_vld = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_vld && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (!rsp_vld) begin
            n_bad++;
            $display("FAIL rsp_timeout got rsp_vld=%b exp 1 after %0d cycles", rsp_vld, cyc);
        end
    endtask

    task automatic ack();
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
    endtask

    // Drives one request to completion and returns what the DUT presented.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic dz, output logic ovf,
                           output int bgns, output int cyc, output logic vld_after);
        int b0;
        b0 = bgn_total;
        send(a, b);
        wait_rsp(cyc);
        q    = rsp_q;
        r    = rsp_r;
        dz   = rsp_dz;
        ovf  = rsp_ovf;
        bgns = bgn_total - b0;
        ack();
        vld_after = rsp_vld;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({req_rdy, div_bgn, rsp_vld, rsp_dz, rsp_ovf} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctrl got rdy,bgn,vld,dz,ovf=%b exp 10000",
                     {req_rdy, div_bgn, rsp_vld, rsp_dz, rsp_ovf});
        end
        n_cmp++;
        if (rsp_q !== 32'h0 || rsp_r !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rsp got q=%h r=%h exp 0 0", rsp_q, rsp_r);
        end
        n_cmp++;
        if (div_ibusA !== 32'h0 || div_ibusB !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_ibus got A=%h B=%h exp 0 0", div_ibusA, div_ibusB);
        end
        rst_b = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_normal();
        logic [W-1:0] va[6] = '{32'd100, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFF9C, 32'd7, 32'h80000000};
        logic [W-1:0] vb[6] = '{32'd7, 32'd7, 32'd2, 32'd10, 32'hFFFFFFFE, 32'd2};
        logic [W-1:0] eq[6] = '{32'd14, 32'hFFFFFFF2, 32'hFFFFFFFD, 32'hFFFFFFF6, 32'hFFFFFFFD, 32'hC0000000};
        logic [W-1:0] er[6] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'd1, 32'h0};
        logic [W-1:0] q, r;
        logic dz, ovf, va_after;
        int bgns, cyc;
        for (int i = 0; i < 6; i++) begin
            run_div(va[i], vb[i], q, r, dz, ovf, bgns, cyc, va_after);
            n_cmp++;
            if (q !== eq[i] || r !== er[i]) begin
                n_bad++;
                $display("FAIL norm%0d_qr got q=%h r=%h exp q=%h r=%h", i, q, r, eq[i], er[i]);
            end
            n_cmp++;
            if ({dz, ovf} !== 2'b00 || bgns != 1) begin
                n_bad++;
                $display("FAIL norm%0d_flags got dz,ovf=%b bgn=%0d exp 00 bgn=1", i, {dz, ovf}, bgns);
            end
            n_cmp++;
            if (cap_a !== va[i] || cap_b !== vb[i] || cyc != dly + 2) begin
                n_bad++;
                $display("FAIL norm%0d_issue got ibus=%h/%h lat=%0d exp %h/%h lat=%0d",
                         i, cap_a, cap_b, cyc, va[i], vb[i], dly + 2);
            end
            n_cmp++;
            if (va_after !== 1'b0 || req_rdy !== 1'b1) begin
                n_bad++;
                $display("FAIL norm%0d_release got vld=%b rdy=%b exp 0 1", i, va_after, req_rdy);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r;
        logic dz, ovf, vld_after;
        int bgns, cyc;
        run_div(32'd5, 32'd0, q, r, dz, ovf, bgns, cyc, vld_after);
        n_cmp++;
        if (q !== 32'hFFFFFFFF || r !== 32'd5 || {dz, ovf} !== 2'b10) begin
            n_bad++;
            $display("FAIL dz_result got q=%h r=%h dz,ovf=%b exp ffffffff 00000005 10", q, r, {dz, ovf});
        end
        n_cmp++;
        if (bgns != 0 || cyc != 0) begin
            n_bad++;
            $display("FAIL dz_timing got bgn=%0d lat=%0d exp 0 0", bgns, cyc);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] q, r;
        logic dz, ovf, vld_after;
        int bgns, cyc;
        run_div(32'h80000000, 32'hFFFFFFFF, q, r, dz, ovf, bgns, cyc, vld_after);
        n_cmp++;
        if (q !== 32'h80000000 || r !== 32'h0 || {dz, ovf} !== 2'b01) begin
            n_bad++;
            $display("FAIL ovf_result got q=%h r=%h dz,ovf=%b exp 80000000 00000000 01", q, r, {dz, ovf});
        end
        n_cmp++;
        if (bgns != 0 || cyc != 0) begin
            n_bad++;
            $display("FAIL ovf_timing got bgn=%0d lat=%0d exp 0 0", bgns, cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        send(32'd100, 32'd7);
        req_a   = 32'd9;
        req_b   = 32'd0;
        req_vld = 1'b1;
        wait_rsp(cyc);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({rsp_vld, req_rdy, rsp_dz, rsp_ovf} !== 4'b1000 || rsp_q !== 32'd14 || rsp_r !== 32'd2) begin
                n_bad++;
                $display("FAIL hold%0d got vld,rdy,dz,ovf=%b q=%h r=%h exp 1000 0000000e 00000002",
                         i, {rsp_vld, req_rdy, rsp_dz, rsp_ovf}, rsp_q, rsp_r);
            end
        end
        ack();
        n_cmp++;
        if (rsp_vld !== 1'b0 || req_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_idle got vld=%b rdy=%b exp 0 1", rsp_vld, req_rdy);
        end
        @(posedge clk); #1;
        req_vld = 1'b0;
        n_cmp++;
        if (rsp_vld !== 1'b1 || rsp_q !== 32'hFFFFFFFF || rsp_r !== 32'd9 || rsp_dz !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_second got vld=%b q=%h r=%h dz=%b exp 1 ffffffff 00000009 1",
                     rsp_vld, rsp_q, rsp_r, rsp_dz);
        end
        ack();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r;
        logic dz, ovf, vld_after;
        int bgns, cyc;
        dly = 20;
        send(32'd1000, 32'd10);
        repeat (5) @(posedge clk);
        #2 rst_b = 1'b0;
        #1;
        n_cmp++;
        if ({req_rdy, div_bgn, rsp_vld, rsp_dz, rsp_ovf} !== 5'b10000 ||
            div_ibusA !== 32'h0 || div_ibusB !== 32'h0 || rsp_q !== 32'h0 || rsp_r !== 32'h0) begin
            n_bad++;
            $display("FAIL midrst_out got ctrl=%b ibus=%h/%h q=%h r=%h exp 10000 all zero",
                     {req_rdy, div_bgn, rsp_vld, rsp_dz, rsp_ovf}, div_ibusA, div_ibusB, rsp_q, rsp_r);
        end
        #3 rst_b = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        n_cmp++;
        if (rsp_vld !== 1'b0 || req_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_quiet got vld=%b rdy=%b exp 0 1", rsp_vld, req_rdy);
        end
        dly = 3;
        run_div(32'd1000, 32'hFFFFFFF6, q, r, dz, ovf, bgns, cyc, vld_after);
        n_cmp++;
        if (q !== 32'hFFFFFF9C || r !== 32'h0 || {dz, ovf} !== 2'b00 || bgns != 1) begin
            n_bad++;
            $display("FAIL midrst_fresh got q=%h r=%h dz,ovf=%b bgn=%0d exp ffffff9c 00000000 00 1",
                     q, r, {dz, ovf}, bgns);
        end
    endtask

`ifdef DIV_TIMEOUT_EN
    task automatic test_timeout();
        logic [W-1:0] q, r;
        logic dz, ovf, vld_after;
        int bgns, cyc;
        fin_en = 1'b0;
        run_div(32'd50, 32'd5, q, r, dz, ovf, bgns, cyc, vld_after);
        fin_en = 1'b1;
        n_cmp++;
        if (q !== 32'h0 || r !== 32'h0 || {dz, ovf} !== 2'b11 || cyc != 256) begin
            n_bad++;
            $display("FAIL tmo_result got q=%h r=%h dz,ovf=%b lat=%0d exp 0 0 11 256", q, r, {dz, ovf}, cyc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
`ifdef DIV_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
